// File: rtl/parport_multi_avalon.sv
// -----------------------------------------------------------------------------
// parport_multi_avalon
//
// Multi-channel programmable parallel port behind an Avalon-MM slave.
// Each channel has a direction register, an output data register with
// atomic set/clear/toggle aliases, a 2-flop synchronized view of the pads,
// rising-edge capture and an interrupt mask. The top level owns the tristate
// buffers; this block only produces data and enable vectors.
//
// Register map, word address = ch*8 + reg:
//   0 DIR    r/w  1 = output
//   1 PIN    ro   synchronized pad state (independent of DIR)
//   2 PORT   r/w  output data
//   3 SET    wo   PORT |= wd
//   4 CLR    wo   PORT &= ~wd
//   5 TOGGLE wo   PORT ^= wd
//   6 MASK   r/w  interrupt mask
//   7 EDGE   r/w1c captured rising edges
// Write-only registers and channels >= NUM_CH read as 0.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     word address (ADDR_W bits)
//   chipselect  slave select
//   read        read strobe (qualified by chipselect)
//   write       write strobe (qualified by chipselect)
//   writedata   32-bit write data, bits above WIDTH ignored
//   readdata    registered read data, 1-cycle latency, holds when idle
//   pins_in     pad inputs, channel c at [c*WIDTH +: WIDTH]
//   pins_out    PORT registers
//   pins_oe     DIR registers
//   irq         registered OR over channels of (EDGE & MASK)
// -----------------------------------------------------------------------------
module parport_multi_avalon #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    input  logic [NUM_CH*WIDTH-1:0] pins_in,
    output logic [NUM_CH*WIDTH-1:0] pins_out,
    output logic [NUM_CH*WIDTH-1:0] pins_oe,
    output logic                    irq
);

    localparam int TW = NUM_CH * WIDTH;

    localparam logic [2:0] REG_DIR  = 3'd0;
    localparam logic [2:0] REG_PIN  = 3'd1;
    localparam logic [2:0] REG_PORT = 3'd2;
    localparam logic [2:0] REG_SET  = 3'd3;
    localparam logic [2:0] REG_CLR  = 3'd4;
    localparam logic [2:0] REG_TOG  = 3'd5;
    localparam logic [2:0] REG_MASK = 3'd6;
    localparam logic [2:0] REG_EDGE = 3'd7;

    // Address decode
    logic [ADDR_W-1:0] ch_num_s;
    logic [2:0]        reg_idx_s;
    logic [NUM_CH-1:0] ch_hit_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic [WIDTH-1:0]  wd_s;

    // Architectural state
    logic [TW-1:0] dir_q,  dir_d;
    logic [TW-1:0] port_q, port_d;
    logic [TW-1:0] mask_q, mask_d;
    logic [TW-1:0] edge_q, edge_d;
    logic [TW-1:0] sync1_q;
    logic [TW-1:0] sync2_q;
    logic [TW-1:0] prev_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          irq_q, irq_d;

    logic [TW-1:0] rise_s;
    logic [TW-1:0] w1c_s;

    // Registers of the addressed channel, zero when no channel matches
    logic [WIDTH-1:0] sel_dir_s;
    logic [WIDTH-1:0] sel_pin_s;
    logic [WIDTH-1:0] sel_port_s;
    logic [WIDTH-1:0] sel_mask_s;
    logic [WIDTH-1:0] sel_edge_s;

    assign ch_num_s  = address >> 3'd3;
    assign reg_idx_s = address[2:0];
    assign wr_en_s   = chipselect & write;
    assign rd_en_s   = chipselect & read;
    assign wd_s      = writedata[WIDTH-1:0];

    // Writedata bits above WIDTH carry no meaning for this port.
    generate
        if (WIDTH < 32) begin : g_wd_upper
            logic unused_wd_s;
            assign unused_wd_s = ^writedata[31:WIDTH];
        end
    endgenerate

    // Per-channel address match; channels >= NUM_CH never match, so their
    // writes vanish and their reads fall through to 0.
    always_comb begin
        ch_hit_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_hit_s[c] = (ch_num_s == ADDR_W'(c));
        end
    end

    assign rise_s = sync2_q & ~prev_q;

    // Next-state for DIR/PORT/MASK and the write-1-to-clear vector
    always_comb begin
        dir_d  = dir_q;
        port_d = port_q;
        mask_d = mask_q;
        w1c_s  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en_s && ch_hit_s[c]) begin
                case (reg_idx_s)
                    REG_DIR:  dir_d[c*WIDTH +: WIDTH]  = wd_s;
                    REG_PORT: port_d[c*WIDTH +: WIDTH] = wd_s;
                    REG_SET:  port_d[c*WIDTH +: WIDTH] = port_q[c*WIDTH +: WIDTH] | wd_s;
                    REG_CLR:  port_d[c*WIDTH +: WIDTH] = port_q[c*WIDTH +: WIDTH] & ~wd_s;
                    REG_TOG:  port_d[c*WIDTH +: WIDTH] = port_q[c*WIDTH +: WIDTH] ^ wd_s;
                    REG_MASK: mask_d[c*WIDTH +: WIDTH] = wd_s;
                    REG_EDGE: w1c_s[c*WIDTH +: WIDTH]  = wd_s;
                    default:  w1c_s[c*WIDTH +: WIDTH]  = {WIDTH{1'b0}};
                endcase
            end else begin
                w1c_s[c*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end
        end
    end

    // Edge capture: clear is applied first so a fresh edge in the same cycle
    // as a clear still leaves the bit set.
    always_comb begin
        edge_d = (edge_q & ~w1c_s) | rise_s;
    end

    // Interrupt from the registered edge/mask state
    always_comb begin
        irq_d = |(edge_q & mask_q);
    end

    // Gather the addressed channel's registers for the read path
    always_comb begin
        sel_dir_s  = '0;
        sel_pin_s  = '0;
        sel_port_s = '0;
        sel_mask_s = '0;
        sel_edge_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_dir_s  = sel_dir_s  | (ch_hit_s[c] ? dir_q[c*WIDTH +: WIDTH]   : {WIDTH{1'b0}});
            sel_pin_s  = sel_pin_s  | (ch_hit_s[c] ? sync2_q[c*WIDTH +: WIDTH] : {WIDTH{1'b0}});
            sel_port_s = sel_port_s | (ch_hit_s[c] ? port_q[c*WIDTH +: WIDTH]  : {WIDTH{1'b0}});
            sel_mask_s = sel_mask_s | (ch_hit_s[c] ? mask_q[c*WIDTH +: WIDTH]  : {WIDTH{1'b0}});
            sel_edge_s = sel_edge_s | (ch_hit_s[c] ? edge_q[c*WIDTH +: WIDTH]  : {WIDTH{1'b0}});
        end
    end

    // Read data mux: uses pre-edge state, so a same-cycle write returns the
    // old value; readdata holds when no read is in progress.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en_s) begin
            case (reg_idx_s)
                REG_DIR:  rdata_d = 32'(sel_dir_s);
                REG_PIN:  rdata_d = 32'(sel_pin_s);
                REG_PORT: rdata_d = 32'(sel_port_s);
                REG_MASK: rdata_d = 32'(sel_mask_s);
                REG_EDGE: rdata_d = 32'(sel_edge_s);
                default:  rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Bus-visible control and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_q  <= '0;
            port_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
        end else begin
            dir_q  <= dir_d;
            port_q <= port_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
        end
    end

    // Pad synchronizer and previous-sample register for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= pins_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Registered read data and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'h0000_0000;
            irq_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign pins_out = port_q;
    assign pins_oe  = dir_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_parport_multi_avalon.sv
module tb_parport_multi_avalon;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 5;
    localparam int TW     = NUM_CH * WIDTH;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [TW-1:0]     pins_in;
    logic [TW-1:0]     pins_out;
    logic [TW-1:0]     pins_oe;
    logic              irq;

    always #5 clk = ~clk;

    parport_multi_avalon #(
        .NUM_CH(NUM_CH),
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .pins_in   (pins_in),
        .pins_out  (pins_out),
        .pins_oe   (pins_oe),
        .irq       (irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (per-channel arrays) ----------------
    logic [WIDTH-1:0] m_dir  [NUM_CH];
    logic [WIDTH-1:0] m_port [NUM_CH];
    logic [WIDTH-1:0] m_mask [NUM_CH];
    logic [WIDTH-1:0] m_edge [NUM_CH];
    // pad value as seen 1, 2 and 3 clocks ago
    logic [WIDTH-1:0] m_pad1 [NUM_CH];
    logic [WIDTH-1:0] m_pad2 [NUM_CH];
    logic [WIDTH-1:0] m_pad3 [NUM_CH];
    logic [WIDTH-1:0] m_rise [NUM_CH];
    logic             m_irq;
    logic             m_irq_n;
    logic [31:0]      m_rd_last;
    bit               rd_seen;
    int               m_ch;
    int               m_reg;
    logic [WIDTH-1:0] m_wd;

    typedef struct packed {
        logic        has;
        logic [31:0] v;
    } cexp_t;

    logic [31:0] mq[$];   // model-predicted read data
    cexp_t       cq[$];   // hand-computed constant for directed reads

    function automatic logic [31:0] model_rd(input logic [ADDR_W-1:0] a);
        int ch;
        int r;
        logic [31:0] v;
        ch = int'(a[4:3]);
        r  = int'(a[2:0]);
        v  = 32'h0;
        if (ch < NUM_CH) begin
            case (r)
                0:       v = 32'(m_dir[ch]);
                1:       v = 32'(m_pad2[ch]);
                2:       v = 32'(m_port[ch]);
                6:       v = 32'(m_mask[ch]);
                7:       v = 32'(m_edge[ch]);
                default: v = 32'h0;
            endcase
        end
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_dir[c]  = '0;
                m_port[c] = '0;
                m_mask[c] = '0;
                m_edge[c] = '0;
                m_pad1[c] = '0;
                m_pad2[c] = '0;
                m_pad3[c] = '0;
            end
            m_irq     = 1'b0;
            m_rd_last = 32'h0;
            rd_seen   = 1'b0;
            mq.delete();
            cq.delete();
        end else begin
            m_irq_n = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if ((m_edge[c] & m_mask[c]) != '0) m_irq_n = 1'b1;
                m_rise[c] = m_pad2[c] & ~m_pad3[c];
            end
            rd_seen = chipselect && read;
            if (rd_seen) begin
                m_rd_last = model_rd(address);
                mq.push_back(m_rd_last);
            end
            if (chipselect && write) begin
                m_ch  = int'(address[4:3]);
                m_reg = int'(address[2:0]);
                m_wd  = writedata[WIDTH-1:0];
                if (m_ch < NUM_CH) begin
                    case (m_reg)
                        0:       m_dir[m_ch]  = m_wd;
                        2:       m_port[m_ch] = m_wd;
                        3:       m_port[m_ch] = m_port[m_ch] | m_wd;
                        4:       m_port[m_ch] = m_port[m_ch] & ~m_wd;
                        5:       m_port[m_ch] = m_port[m_ch] ^ m_wd;
                        6:       m_mask[m_ch] = m_wd;
                        7:       m_edge[m_ch] = m_edge[m_ch] & ~m_wd;
                        default: ;
                    endcase
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                m_edge[c] = m_edge[c] | m_rise[c];
                m_pad3[c] = m_pad2[c];
                m_pad2[c] = m_pad1[c];
                m_pad1[c] = pins_in[c*WIDTH +: WIDTH];
            end
            m_irq = m_irq_n;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    cexp_t ce;
    logic [31:0] me;
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_seen) begin
                if (mq.size() == 0 || cq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_queue: got empty queue expected an entry at %0t", $time);
                end else begin
                    me = mq.pop_front();
                    ce = cq.pop_front();
                    chk("readdata", readdata, me);
                    if (ce.has) chk("readdata_const", readdata, ce.v);
                end
            end else begin
                chk("readdata_hold", readdata, m_rd_last);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                chk("pins_out", 32'(pins_out[c*WIDTH +: WIDTH]), 32'(m_port[c]));
                chk("pins_oe",  32'(pins_oe[c*WIDTH +: WIDTH]),  32'(m_dir[c]));
            end
            chk("irq", 32'(irq), 32'(m_irq));
        end
    end

    // ---------------- drivers ----------------
    task automatic drv_idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic drv_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b0;
        write      = 1'b1;
        address    = a;
        writedata  = d;
    endtask

    task automatic drv_rd(input logic [ADDR_W-1:0] a, input logic h, input logic [31:0] v);
        cexp_t e;
        e.has      = h;
        e.v        = v;
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = a;
        cq.push_back(e);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        drv_wr(a, d);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic h, input logic [31:0] v);
        @(negedge clk);
        drv_rd(a, h, v);
    endtask

    task automatic idle();
        @(negedge clk);
        drv_idle();
    endtask

    int op;

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        writedata = 32'h0;
        pins_in   = '0;
        drv_idle();
        repeat (3) @(negedge clk);
        chk("reset_pins_out", 32'(pins_out), 32'h0);
        chk("reset_pins_oe",  32'(pins_oe),  32'h0);
        chk("reset_irq",      32'(irq),      32'h0);
        chk("reset_readdata", readdata,      32'h0);
        reset_n = 1'b1;

        // Reset values of every readable control register
        for (int c = 0; c < NUM_CH; c++) begin
            rd(ADDR_W'(c*8 + 0), 1'b1, 32'h0);
            rd(ADDR_W'(c*8 + 2), 1'b1, 32'h0);
            rd(ADDR_W'(c*8 + 6), 1'b1, 32'h0);
            rd(ADDR_W'(c*8 + 7), 1'b1, 32'h0);
        end
        idle();

        // Channel 1 atomic ops: 0x0F | 0xA0 = 0xAF, & ~0x03 = 0xAC, ^ 0xFF = 0x53
        wr(5'd10, 32'h0000_000F);
        wr(5'd11, 32'h0000_00A0);
        wr(5'd12, 32'h0000_0003);
        wr(5'd13, 32'hFFFF_FFFF);
        idle();
        chk("ch1_pins_out", 32'(pins_out), 32'h0000_5300);
        rd(5'd10, 1'b1, 32'h53);
        idle();

        // Channel 2 pad 0x00 -> 0x81: PIN after 2 clocks, EDGE after 3
        @(negedge clk);
        pins_in[23:16] = 8'h81;
        drv_rd(5'd17, 1'b1, 32'h00);
        rd(5'd17, 1'b1, 32'h00);
        rd(5'd17, 1'b1, 32'h81);
        rd(5'd23, 1'b1, 32'h81);
        wr(5'd22, 32'h0000_0001);
        idle();
        @(negedge clk);
        chk("ch2_irq_set", 32'(irq), 32'h1);
        wr(5'd23, 32'h0000_0001);
        idle();
        @(negedge clk);
        chk("ch2_irq_clr", 32'(irq), 32'h0);
        rd(5'd23, 1'b1, 32'h80);
        idle();

        // Clear of EDGE bit 3 on ch0 collides with its rise
        @(negedge clk);
        pins_in[3] = 1'b1;
        idle();
        wr(5'd7, 32'h0000_0008);
        @(negedge clk);
        pins_in[3] = 1'b0;
        drv_rd(5'd7, 1'b1, 32'h08);
        idle();

        // Channel 3 does not exist
        wr(5'd26, 32'h0000_00FF);
        idle();
        chk("ch3_pins_out", 32'(pins_out), 32'h0000_5300);
        chk("ch3_pins_oe",  32'(pins_oe),  32'h0);
        rd(5'd26, 1'b1, 32'h0);
        rd(5'd24, 1'b1, 32'h0);
        idle();

        // Mid-cycle asynchronous reset
        wr(5'd0, 32'h0000_00FF);
        wr(5'd2, 32'h0000_0055);
        idle();
        pins_in = '0;
        chk("pre_rst_out", 32'(pins_out[7:0]), 32'h55);
        chk("pre_rst_oe",  32'(pins_oe[7:0]),  32'hFF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(pins_out), 32'h0);
        chk("async_rst_oe",  32'(pins_oe),  32'h0);
        chk("async_rst_irq", 32'(irq),      32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) idle();
        rd(5'd7,  1'b1, 32'h0);
        rd(5'd15, 1'b1, 32'h0);
        rd(5'd23, 1'b1, 32'h0);
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            pins_in = pins_in ^ TW'($urandom & $urandom & $urandom);
            op = int'($urandom_range(0, 9));
            if (op < 4) begin
                drv_wr(ADDR_W'($urandom_range(0, 31)), $urandom);
            end else if (op < 7) begin
                drv_rd(ADDR_W'($urandom_range(0, 31)), 1'b0, 32'h0);
            end else begin
                drv_idle();
            end
        end
        idle();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parport_multi_avalon.md
Name: parport_multi_avalon

Overview:
- Multi-channel programmable parallel port on an Avalon-MM slave. Successor to the fixed three-output, 8-bit parallel ports in the soc_system.
- Adds per-bit direction control, atomic set/clear/toggle, a 2-flop input synchronizer, rising-edge capture, and a masked level interrupt.
- Sits between the HPS/Nios bus and FPGA GPIO pins. The top level owns the tristate buffers.

Parameters:
- NUM_CH, 3: number of independent port channels (1..4).
- WIDTH, 8: bits per channel (1..32).
- ADDR_W, 5: Avalon word-address width. Constraint: NUM_CH*8 <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  word address = ch*8 + reg.
- chipselect  in  1  slave select.
- read  in  1  read strobe; valid only with chipselect.
- write  in  1  write strobe; valid only with chipselect.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- pins_in  in  NUM_CH*WIDTH  pad inputs; channel c occupies bits [c*WIDTH +: WIDTH].
- pins_out  out  NUM_CH*WIDTH  output data, equal to the PORT registers.
- pins_oe  out  NUM_CH*WIDTH  output enables, equal to the DIR registers.
- irq  out  1  OR over all channels of (EDGE & MASK).

Behaviour:
- Register map per channel (reg index):
  - 0 DIR (r/w, 1 = output)
  - 1 PIN (read-only, synchronized pins_in)
  - 2 PORT (r/w)
  - 3 SET (write-only, PORT |= wd)
  - 4 CLR (write-only, PORT &= ~wd)
  - 5 TOGGLE (write-only, PORT ^= wd)
  - 6 MASK (r/w)
  - 7 EDGE (read; write-1-to-clear)
  - Write-only registers read as 0.
- Reset (asynchronous): DIR, PORT, MASK, EDGE, synchronizer stages, previous-sample register and readdata all go to 0. So pins_out=0, pins_oe=0, irq=0, and all pins are inputs.
- Writes take effect on the clock edge where chipselect&write. The new value is visible on pins_out/pins_oe the next cycle.
- Reads: readdata is registered with 1-cycle latency (sampled on the edge where chipselect&read, valid the following cycle). readdata holds its value when not reading.
- Simultaneous read and write to the same register returns the old value.
- Input path:
  - sync1 <= pins_in; sync2 <= sync1; prev <= sync2.
  - PIN = sync2.
  - Rising-edge detect: rise = sync2 & ~prev.
  - Pin change to PIN visible: 2 cycles. Change to EDGE bit set: 3 cycles after the pad change.
- PIN reflects pad state regardless of DIR. Output-driven pins are looped back through the top-level buffers.
- EDGE update per bit: EDGE <= (EDGE & ~w1c) | rise. A new edge in the same cycle as a clear leaves the bit set.
- irq is registered: it asserts 1 cycle after EDGE&MASK becomes nonzero and deasserts 1 cycle after the last contributing bit is cleared or masked.
- Address with channel index >= NUM_CH: writes are ignored, reads return 0, and no bus error is raised.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Pending edges are lost. The first sample after release never produces a spurious edge because prev=0 and the synchronizers are 0.
- No wait states; waitrequest is not provided.

Test Plan:
- Reset, then read DIR/PORT/MASK/EDGE of all channels -> each returns 0; pins_oe=0, irq=0.
- Channel 1: write PORT=0x0F, SET=0xA0, CLR=0x03, TOGGLE=0xFF -> PORT reads 0x53; pins_out[15:8]=0x53 one cycle after the last write. Channels 0 and 2 stay unchanged.
- Channel 2: pins_in[23:16] goes 0x00->0x81 -> PIN reads 0x81 after 2 cycles; EDGE reads 0x81 from cycle 3. Set MASK=0x01 -> irq=1 one cycle later. Write EDGE=0x01 -> irq=0; EDGE reads 0x80.
- Clear/edge collision: pulse channel 0 bit 3 high so rise coincides with a write of EDGE=0x08 -> EDGE bit 3 remains 1.
- With NUM_CH=3, write address 26 (channel 3, PORT) with 0xFF -> no output changes; read address 26 -> 0.
- Drive DIR=0xFF, PORT=0x55 on channel 0, then assert reset_n=0 mid-cycle -> pins_out and pins_oe go to 0 before the next clock edge; after release, EDGE stays 0.
